// File: rtl/dsp_chain.sv
// Audio DSP chain: moving-average FIR, feedback echo and bypass, with a
// click-free gain fade around every change of the applied mode.
module dsp_chain #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned FIR_LOG_TAPS = 2,
  parameter int unsigned ECHO_DELAY   = 4096,
  parameter int unsigned ECHO_SHIFT   = 1,
  parameter int unsigned RAMP_LOG     = 4
) (
  input  logic                     sample_clock,
  input  logic                     reset,
  input  logic [1:0]               selector,
  input  logic signed [DATA_W-1:0] input_sample,
  output logic signed [DATA_W-1:0] output_sample,
  output logic [1:0]               active_mode,
  output logic                     busy
);

  localparam int unsigned Taps  = 1 << FIR_LOG_TAPS;
  localparam int unsigned SumW  = DATA_W + FIR_LOG_TAPS;
  localparam int unsigned PtrW  = $clog2(ECHO_DELAY);
  localparam int unsigned FillW = $clog2(ECHO_DELAY + 1);
  localparam int unsigned GainW = RAMP_LOG + 1;
  localparam int unsigned ProdW = DATA_W + RAMP_LOG + 2;
  localparam logic [GainW-1:0] GainMax = GainW'(1 << RAMP_LOG);

  typedef enum logic [1:0] {StRun, StFadeOut, StFadeIn} state_e;

  // ---------------------------------------------------------------------------
  // Stage 1: capture x and form the FIR output from a running sum
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] hist_q [Taps];
  logic signed [SumW-1:0]   sum_q, sum_d;
  logic signed [DATA_W-1:0] fir_now;
  logic signed [DATA_W-1:0] x_q, f_q;
  logic                     vld_q;

  always_comb begin
    sum_d   = sum_q + SumW'(input_sample) - SumW'(hist_q[Taps-1]);
    fir_now = DATA_W'(sum_d >>> FIR_LOG_TAPS);
  end

  always_ff @(posedge sample_clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < Taps; i++) hist_q[i] <= '0;
      sum_q <= '0;
      x_q   <= '0;
      f_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      hist_q[0] <= input_sample;
      for (int unsigned i = 1; i < Taps; i++) hist_q[i] <= hist_q[i-1];
      sum_q <= sum_d;
      x_q   <= input_sample;
      f_q   <= fir_now;
      vld_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: echo recursion and mode select
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] echo_mem [ECHO_DELAY];
  logic [PtrW-1:0]          ptr_q;
  logic [FillW-1:0]         fill_q;
  logic                     fill_full;
  logic signed [DATA_W-1:0] echo_in, echo_old, echo_now;
  logic signed [DATA_W:0]   echo_sum;
  logic signed [DATA_W-1:0] y_q;
  logic [1:0]               mode_q, mode_d;

  always_comb begin
    fill_full = (fill_q == FillW'(ECHO_DELAY));
    echo_in   = (mode_q == 2'b11) ? f_q : x_q;
    // Buffer is never cleared; entries are ignored until a full delay is written.
    echo_old  = fill_full ? echo_mem[ptr_q] : '0;
    echo_sum  = (DATA_W+1)'(echo_in) + (DATA_W+1)'(echo_old >>> ECHO_SHIFT);
    if (echo_sum[DATA_W] != echo_sum[DATA_W-1]) begin
      echo_now = echo_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      echo_now = echo_sum[DATA_W-1:0];
    end
  end

  always_ff @(posedge sample_clock) begin
    if (!reset && vld_q) echo_mem[ptr_q] <= echo_now;
  end

  always_ff @(posedge sample_clock) begin
    if (reset) begin
      ptr_q  <= '0;
      fill_q <= '0;
      y_q    <= '0;
    end else begin
      if (vld_q) begin
        ptr_q <= (ptr_q == PtrW'(ECHO_DELAY - 1)) ? '0 : ptr_q + 1'b1;
        if (!fill_full) fill_q <= fill_q + 1'b1;
      end
      unique case (mode_q)
        2'b00:   y_q <= x_q;
        2'b01:   y_q <= f_q;
        default: y_q <= echo_now;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Fade FSM and output gain stage
  // ---------------------------------------------------------------------------
  state_e                   state_q, state_d;
  logic [GainW-1:0]         gain_q, gain_d;
  logic                     fade_down;
  logic                     busy_q;
  logic signed [ProdW-1:0]  prod;

  always_comb begin
    state_d   = state_q;
    gain_d    = gain_q;
    mode_d    = mode_q;
    fade_down = 1'b0;
    unique case (state_q)
      StRun: begin
        gain_d = GainMax;
        if (selector != mode_q) state_d = StFadeOut;
      end
      StFadeOut: fade_down = 1'b1;
      StFadeIn: begin
        if (selector != mode_q) begin
          fade_down = 1'b1;
        end else if (gain_q >= GainMax - 1'b1) begin
          gain_d  = GainMax;
          state_d = StRun;
        end else begin
          gain_d = gain_q + 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
    // Mode is swapped only at zero gain, whatever the selector did meanwhile.
    if (fade_down) begin
      if (gain_q <= GainW'(1)) begin
        gain_d  = '0;
        mode_d  = selector;
        state_d = StFadeIn;
      end else begin
        gain_d  = gain_q - 1'b1;
        state_d = StFadeOut;
      end
    end
  end

  always_ff @(posedge sample_clock) begin
    if (reset) begin
      state_q <= StRun;
      gain_q  <= GainMax;
      mode_q  <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      mode_q  <= mode_d;
      busy_q  <= (state_d != StRun);
    end
  end

  always_comb begin
    prod = ProdW'(y_q) * ProdW'($signed({1'b0, gain_q}));
  end

  always_ff @(posedge sample_clock) begin
    if (reset) output_sample <= '0;
    else       output_sample <= DATA_W'(prod >>> RAMP_LOG);
  end

  assign active_mode = mode_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dsp_chain.sv
// Directed bench for dsp_chain: N=4 FIR, D=8 echo with shift 1, R=16 fades.
module tb_dsp_chain;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           sel = 2'b00;
  logic signed [DW-1:0] x   = '0;
  logic signed [DW-1:0] y;
  logic [1:0]           mode;
  logic                 busy;

  dsp_chain #(
    .DATA_W      (DW),
    .FIR_LOG_TAPS(2),
    .ECHO_DELAY  (8),
    .ECHO_SHIFT  (1),
    .RAMP_LOG    (4)
  ) dut (
    .sample_clock (clk),
    .reset        (rst),
    .selector     (sel),
    .input_sample (x),
    .output_sample(y),
    .active_mode  (mode),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] sel;
    int         x;
    int         reps;
    int         exp_out;
    int         exp_mode;
    int         exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] s, input int xv, input int reps, input int eo,
                     input int em, input int eb);
    vec_t v;
    v.sel = s; v.x = xv; v.reps = reps; v.exp_out = eo; v.exp_mode = em; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs, advance one sample, sample outputs 1 time unit after the edge.
  task automatic step(input logic [1:0] s, input int xv);
    sel = s;
    x   = DW'(xv);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] s);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(s, int'($urandom_range(0, 65535)) - 32768);
    rst = 1'b0;
  endtask

  // Gain after edge k for a plain switch detected at edge 0.
  function automatic int g_switch(input int k);
    if (k <= 0) return 16;
    if (k <= 16) return 16 - k;
    if (k <= 32) return k - 16;
    return 16;
  endfunction

  // Gain after edge k: switch at edge 0, abort at g = 5 (edge 22).
  function automatic int g_abort(input int k);
    if (k <= 0) return 16;
    if (k <= 16) return 16 - k;
    if (k <= 21) return k - 16;
    return 26 - k;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int bad;

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(2'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768);
      check($sformatf("rst%0d_out", i), int'(y), 0);
      check($sformatf("rst%0d_mode", i), int'(mode), 0);
      check($sformatf("rst%0d_busy", i), int'(busy), 0);
    end
    rst = 1'b0;

    // Bypass latency, settle into FIR, FIR step and floor behaviour
    add(2'b00, 1234, 1, 0, 0, 0);
    add(2'b00, 1234, 1, 0, 0, 0);
    add(2'b00, 1234, 1, 1234, 0, 0);
    add(2'b00, 1234, 5, 1234, 0, 0);
    add(2'b01, 0, 40, 0, 1, 0);
    add(2'b01, 400, 1, 0, 1, 0);
    add(2'b01, 400, 1, 0, 1, 0);
    add(2'b01, 400, 1, 100, 1, 0);
    add(2'b01, 400, 1, 200, 1, 0);
    add(2'b01, 400, 1, 300, 1, 0);
    add(2'b01, 400, 1, 400, 1, 0);
    add(2'b01, 400, 1, 400, 1, 0);
    add(2'b01, -1, 1, 400, 1, 0);
    add(2'b01, -1, 1, 400, 1, 0);
    add(2'b01, -1, 1, 299, 1, 0);
    add(2'b01, -1, 1, 199, 1, 0);
    add(2'b01, -1, 1, 99, 1, 0);
    add(2'b01, -1, 1, -1, 1, 0);
    add(2'b01, -1, 3, -1, 1, 0);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) step(vecs[i].sel, vecs[i].x);
      check($sformatf("vec%0d_out", i), int'(y), vecs[i].exp_out);
      check($sformatf("vec%0d_mode", i), int'(mode), vecs[i].exp_mode);
      check($sformatf("vec%0d_busy", i), int'(busy), vecs[i].exp_busy);
    end

    // Back to bypass with x = 1600
    for (int e = 0; e < 40; e++) step(2'b00, 1600);
    check("pre_sw_mode", int'(mode), 0);
    check("pre_sw_busy", int'(busy), 0);

    // Full fade 00 -> 01
    cnt = 0;
    for (int e = 0; e < 40; e++) begin
      step(2'b01, 1600);
      check($sformatf("sw_out_e%0d", e), int'(y), 100 * g_switch(e - 1));
      if (busy) cnt++;
      if (e == 15) check("sw_mode_e15", int'(mode), 0);
      if (e == 16) check("sw_mode_e16", int'(mode), 1);
    end
    check("sw_busy_cycles", cnt, 32);

    // Abort during fade-in at g = 5
    cnt = 0;
    for (int e = 0; e < 46; e++) begin
      step((e < 22) ? 2'b00 : 2'b10, 1600);
      if (e <= 27) check($sformatf("ab_out_e%0d", e), int'(y), 100 * g_abort(e - 1));
      if (busy) cnt++;
      if (e == 25) check("ab_mode_e25", int'(mode), 0);
      if (e == 26) check("ab_mode_e26", int'(mode), 2);
    end
    check("ab_busy_cycles", cnt, 42);
    check("ab_busy_end", int'(busy), 0);

    // Selector 01 then 00 during fade-out latches 00
    cnt = 0;
    for (int e = 0; e < 40; e++) begin
      step((e < 5) ? 2'b01 : 2'b00, 1600);
      if (busy) cnt++;
      if (e == 15) check("tg_mode_e15", int'(mode), 2);
      if (e == 16) check("tg_mode_e16", int'(mode), 0);
      if (e == 17) check("tg_out_e17", int'(y), 0);
    end
    check("tg_busy_cycles", cnt, 32);

    // Selector returns to the old mode: fade still completes
    cnt = 0;
    for (int e = 0; e < 40; e++) begin
      step((e < 3) ? 2'b01 : 2'b00, 1600);
      check($sformatf("rt_out_e%0d", e), int'(y), 100 * g_switch(e - 1));
      if (busy) cnt++;
    end
    check("rt_busy_cycles", cnt, 32);
    check("rt_mode_end", int'(mode), 0);

    // Echo saturation
    do_reset(2'b10);
    bad = 0;
    for (int e = 0; e < 60; e++) begin
      step(2'b10, 30000);
      if (int'(y) < 0) bad++;
      if (e >= 34 && int'(y) != 32767) bad++;
    end
    check("sat_bad_samples", bad, 0);
    check("sat_final", int'(y), 32767);

    // Reset in the middle of a fade
    for (int e = 0; e < 6; e++) step(2'b00, 30000);
    check("mid_busy", int'(busy), 1);
    rst = 1'b1;
    step(2'b10, 0);
    check("mid_rst_mode", int'(mode), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_out", int'(y), 0);
    step(2'b10, 0);
    step(2'b10, 0);
    rst = 1'b0;

    // Warm-up: stale buffer contents must not echo
    bad = 0;
    for (int e = 0; e < 60; e++) begin
      step(2'b10, 0);
      if (int'(y) != 0) bad++;
    end
    check("warmup_nonzero", bad, 0);
    check("warmup_mode", int'(mode), 2);

    // Echo impulse
    for (int e = 0; e < 34; e++) begin
      int exp;
      step(2'b10, (e == 0) ? 1000 : 0);
      exp = (e == 2) ? 1000 : (e == 10) ? 500 : (e == 18) ? 250 : (e == 26) ? 125 : 0;
      check($sformatf("imp_out_e%0d", e), int'(y), exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_chain.md
# dsp_chain

Parametrised audio DSP chain running one sample per `sample_clock` cycle: a moving-average FIR, a feedback echo and a bypass path, selected by a 2-bit mode including an FIR→echo cascade. Mode changes are click-free: the output fades to zero, switches mode, then fades back in. It sits between the codec sample interface and the codec output register, and replaces the fixed 16-bit three-way filter/echo/bypass selector.

## Interface
- `DATA_W`, 16: sample width, signed two's complement.
- `FIR_LOG_TAPS`, 2: FIR length N = 2^FIR_LOG_TAPS taps, equal weights; range 1..6.
- `ECHO_DELAY`, 4096: echo delay D in samples; range 2..65536.
- `ECHO_SHIFT`, 1: echo feedback attenuation, feedback term = e[n-D] >>> ECHO_SHIFT; range 1..8.
- `RAMP_LOG`, 4: fade length R = 2^RAMP_LOG samples per fade direction.
- `sample_clock`, in, 1: the only clock; one sample per rising edge.
- `reset`, in, 1: synchronous, active-high.
- `selector`, in, 2: requested mode; 00 bypass, 01 FIR, 10 echo, 11 FIR then echo.
- `input_sample`, in, DATA_W: x[n], signed.
- `output_sample`, out, DATA_W: processed, gain-scaled sample, signed.
- `active_mode`, out, 2: mode currently applied.
- `busy`, out, 1: high while fading out or fading in.

## Operation
- **FIR:** f[n] = (x[n] + … + x[n-N+1]) >>> FIR_LOG_TAPS.
  - Keep a running sum of DATA_W+FIR_LOG_TAPS bits: sum += x[n] − x[n-N].
  - The shift is arithmetic (floor). The result always fits in DATA_W, so no saturation is needed.
- **Echo:** e[n] = sat(a[n] + (e[n-D] >>> ECHO_SHIFT)).
  - a = x in modes 00, 01 and 10; a = f in mode 11.
  - The sum is formed at DATA_W+1 bits, then saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - e[n] is written into a D-entry circular buffer; the read and write pointers share one address that wraps from D−1 to 0.
  - The echo path runs in every mode, so its history is continuous across mode switches.
- **Echo warm-up:** a fill counter saturates at D. While fill < D, e[n-D] is treated as 0. The buffer is not cleared on reset.
- **Mode output y[n]:** 00 → x, 01 → f, 10 → e, 11 → e (fed from f).
- **Gain:** a (RAMP_LOG+1)-bit counter g in 0..R.
  - output = (y·g) >>> RAMP_LOG, with the product formed at DATA_W+RAMP_LOG+2 bits.
  - g = R is exact unity.
- **Fade FSM states:** RUN, FADE_OUT, FADE_IN.
  - RUN: g = R. If selector ≠ active_mode, go to FADE_OUT.
  - FADE_OUT: g decrements by 1 per sample. On the cycle g reaches 0, active_mode latches the current `selector` and the state moves to FADE_IN. FADE_OUT always completes, even if `selector` returns to the old mode.
  - FADE_IN: g increments by 1 per sample. At g = R, go to RUN. If selector ≠ active_mode at any point during FADE_IN, go to FADE_OUT and decrement from the current g.
- `busy` = (state ≠ RUN), registered.
- **Reset:** applies to FSM, gain, output, FIR state and echo fill counter, as follows:
  - output_sample = 0, active_mode = 00, state RUN, g = R, busy = 0.
  - FIR history and sum = 0; echo pointer and fill counter = 0.
  - If selector ≠ 00 after reset, a normal fade sequence follows.
  - Reset asserted mid-fade aborts the fade.

## Timing
- Latency is 2 cycles in all modes: x presented before edge k affects `output_sample` after edge k+2. Path latencies are equalised so a mode switch never misaligns samples.
- The gain applied to the output at edge k+2 is the g in effect at edge k+1.
- `active_mode` and `busy` update on the same edge as the FSM state.
- **Full fade sequence** from a selector change in RUN: R cycles fading out, then R cycles fading in.
  - `busy` is high for 2R cycles.
  - `active_mode` changes on edge R after the change is detected.
- **Buffer access:** one read and one write per cycle at the same address (read-before-write). A single-port synchronous RAM with read-old-data semantics is sufficient.
- No throughput stalls: every cycle consumes a sample and produces a sample.

## Test plan
- **Reset:** assert reset 3 cycles with random inputs → output_sample = 0, active_mode = 00, busy = 0. Then selector = 00, x = 1234 → output 1234 after 2 cycles.
- **FIR step** (mode 01 settled, N = 4): x = 0 then step to 400 → outputs 100, 200, 300, 400, 400. x = −1 constant → settles at −1 (floor).
- **Echo impulse** (mode 10, D = 8, shift 1, after warm-up): single x = 1000 → outputs 1000, 500, 250, 125 at 8-sample spacing. Inside the first D samples after reset, no echo appears.
- **Echo saturation:** x = 30000 constant, mode 10 → output clamps at 32767 and never wraps negative.
- **Mode switch** (R = 16, x = 1600 constant, 00 → 01):
  - Output falls by 100 per sample to 0.
  - active_mode = 01 at edge 16.
  - Output rises back to 1600.
  - busy high for exactly 32 cycles.
- **Abort during FADE_IN:** change selector to 10 when g = 5 → g counts down 5→0, active_mode = 10, then fade in. selector toggled 01 → 00 during FADE_OUT → fade completes to 0 and latches 00.
